// File: rtl/aes_pkg.sv
// Shared AES constants, key-scheduler states and helpers.
// AES_EQ_INV_CIPHER_KEY_EN adds InvMixColumns for equivalent-inverse keys.
package aes_pkg;

  localparam int WIDTH_DEF = 128;
  localparam int WORD_W    = 32;
  localparam int NWORDS    = 4;
  localparam logic [3:0] NROUNDS = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    STREAM = 2'd2
  } ks_state_e;

  function automatic logic [WORD_W-1:0] rcon(
    input logic [3:0] i
  );
    logic [7:0] b;
    case (i)
      4'd0:    b = 8'h01;
      4'd1:    b = 8'h02;
      4'd2:    b = 8'h04;
      4'd3:    b = 8'h08;
      4'd4:    b = 8'h10;
      4'd5:    b = 8'h20;
      4'd6:    b = 8'h40;
      4'd7:    b = 8'h80;
      4'd8:    b = 8'h1b;
      4'd9:    b = 8'h36;
      default: b = 8'h00;
    endcase
    return {b, 24'h0};
  endfunction

  function automatic logic [WORD_W-1:0] rot_word(
    input logic [WORD_W-1:0] w
  );
    return {w[23:0], w[31:24]};
  endfunction

`ifdef AES_EQ_INV_CIPHER_KEY_EN
  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [WORD_W-1:0] imc_col(
    input logic [WORD_W-1:0] c
  );
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m2, m4, m8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2    = xt(a[i]);
      m4    = xt(m2);
      m8    = xt(m4);
      m9[i] = m8 ^ a[i];
      mb[i] = m8 ^ m2 ^ a[i];
      md[i] = m8 ^ m4 ^ a[i];
      me[i] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [WIDTH_DEF-1:0] inv_mix_cols(
    input logic [WIDTH_DEF-1:0] k
  );
    return {imc_col(k[127:96]), imc_col(k[95:64]),
            imc_col(k[63:32]),  imc_col(k[31:0])};
  endfunction
`endif

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES forward S-boxes on one 32-bit word.
// Purely combinational; table lookup indexed by the byte value.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255-x)*8, i.e. {~x, 3'b000}.
  function automatic logic [7:0] sb(
    input logic [7:0] x
  );
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  assign word_o = {sb(word_i[31:24]), sb(word_i[23:16]),
                   sb(word_i[15:8]),  sb(word_i[7:0])};

endmodule

// File: rtl/aes128_inv_key_sched.sv
// AES-128 key schedule streaming round keys 10 down to 0.
// AES_EQ_INV_CIPHER_KEY_EN: InvMixColumns on output keys 9..1.
module aes128_inv_key_sched
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             key_valid_i,
  input  logic [WIDTH-1:0] key_ciph_i,
  output logic             key_ready_o,
  output logic [WIDTH-1:0] rkey_o,
  output logic [3:0]       rkey_idx_o,
  output logic             rkey_valid_o,
  input  logic             rkey_ready_i,
  output logic             rkey_last_o
);

  ks_state_e state_q, state_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] n3, sb_in, sb_out, rc;
  logic [WORD_W-1:0] f0, f1, f2, f3;
  logic [WORD_W-1:0] i0;
  logic is_fwd;

  assign {w0, w1, w2, w3} = key_q;
  assign is_fwd = (state_q == FWD);

  // One S-box word serves both directions.
  assign n3    = w3 ^ w2;
  assign sb_in = rot_word(is_fwd ? w3 : n3);
  assign rc    = rcon(is_fwd ? cnt_q : idx_q - 4'd1);

  aes_sbox_word u_sbox (
    .word_i (sb_in),
    .word_o (sb_out)
  );

  assign f0 = w0 ^ sb_out ^ rc;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign i0 = w0 ^ sb_out ^ rc;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          key_d   = key_ciph_i;
          cnt_d   = 4'd0;
          state_d = FWD;
        end
      end
      FWD: begin
        key_d = {f0, f1, f2, f3};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == NROUNDS - 4'd1) begin
          state_d = STREAM;
          idx_d   = NROUNDS;
        end
      end
      STREAM: begin
        if (rkey_ready_i) begin
          if (idx_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            key_d = {i0, w1 ^ w0, w2 ^ w1, n3};
            idx_d = idx_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign key_ready_o  = (state_q == IDLE);
  assign rkey_valid_o = (state_q == STREAM);
  assign rkey_last_o  = rkey_valid_o && (idx_q == 4'd0);
  assign rkey_idx_o   = idx_q;

`ifdef AES_EQ_INV_CIPHER_KEY_EN
  assign rkey_o = (idx_q != 4'd0 && idx_q != NROUNDS)
                ? inv_mix_cols(key_q) : key_q;
`else
  assign rkey_o = key_q;
`endif

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Bench for aes128_inv_key_sched: GF(2^8)-derived reference
// schedule, random keys and random backpressure.
module tb_aes128_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key_ciph;
  logic         key_ready;
  logic [127:0] rkey;
  logic [3:0]   rkey_idx;
  logic         rkey_valid;
  logic         rkey_ready;
  logic         rkey_last;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sb [256];
  logic [127:0] ref_rk [11];
  logic [127:0] obs [11];

  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] DROPK = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes128_inv_key_sched #(.WIDTH(128)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .key_valid_i  (key_valid),
    .key_ciph_i   (key_ciph),
    .key_ready_o  (key_ready),
    .rkey_o       (rkey),
    .rkey_idx_o   (rkey_idx),
    .rkey_valid_o (rkey_valid),
    .rkey_ready_i (rkey_ready),
    .rkey_last_o  (rkey_last)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
            ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] imc_ref(input logic [127:0] k);
    logic [7:0]   cf [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] res = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(cf[(j - i + 4) % 4], k[127-32*c-8*j -: 8]);
        res[127-32*c-8*i -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] exp_key(input int r);
`ifdef AES_EQ_INV_CIPHER_KEY_EN
    if (r >= 1 && r <= 9) return imc_ref(ref_rk[r]);
`endif
    return ref_rk[r];
  endfunction

  // Caller leaves key_valid/key_ciph set at a negedge with the block idle.
  task automatic run_key(input logic [127:0] k, input bit rnd,
                         input bit drop, input bit hold,
                         input logic [127:0] nk, input int abort_at);
    int lat;
    int r;
    int steps;
    expand(k);
    chk("key_ready_idle", key_ready, 1);
    @(negedge clk);
    if (hold) key_ciph = nk;
    else key_valid = 1'b0;
    chk("key_ready_busy", key_ready, 0);
    lat = 0;
    while (!rkey_valid && lat < 20) begin
      if (drop && lat == 3) begin
        key_valid = 1'b1;
        key_ciph  = DROPK;
      end else if (drop && lat == 4) begin
        key_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 10);
    if (!rkey_valid) return;
    r = 10;
    steps = 0;
    while (r >= 0 && steps < 300) begin
      steps++;
      chk($sformatf("valid%0d", r), rkey_valid, 1);
      chk($sformatf("idx%0d", r), rkey_idx, r);
      chk($sformatf("rkey%0d", r), rkey, exp_key(r));
      chk($sformatf("last%0d", r), rkey_last, r == 0);
      obs[r] = rkey;
      if (r == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_rkey", rkey, 0);
        chk("rst_idx", rkey_idx, 0);
        chk("rst_valid", rkey_valid, 0);
        chk("rst_last", rkey_last, 0);
        chk("rst_kready", key_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
      rkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rkey_ready) r--;
    end
    chk("stream_done", r, -1);
    chk("end_kready", key_ready, 1);
    chk("end_valid", rkey_valid, 0);
    chk("end_last", rkey_last, 0);
  endtask

  initial begin
    logic [127:0] ka, kb;
    rst_n      = 1'b0;
    key_valid  = 1'b0;
    key_ciph   = '0;
    rkey_ready = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    chk("reset_kready", key_ready, 1);
    chk("reset_valid", rkey_valid, 0);
    chk("reset_last", rkey_last, 0);
    chk("reset_idx", rkey_idx, 0);
    chk("reset_rkey", rkey, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 key, consumer always ready
    key_valid = 1'b1;
    key_ciph  = FIPS;
    run_key(FIPS, 0, 0, 0, '0, -1);
    chk("fips_idx10", obs[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_idx0", obs[0], FIPS);
`ifdef AES_EQ_INV_CIPHER_KEY_EN
    chk("fips_idx9_imc", obs[9], imc_ref(ref_rk[9]));
`else
    chk("fips_idx1", obs[1], 128'ha0fafe1788542cb123a339392a6c7605);
`endif

    // random backpressure
    key_valid = 1'b1;
    key_ciph  = FIPS;
    run_key(FIPS, 1, 0, 0, '0, -1);

    // key offered while busy is dropped
    key_valid = 1'b1;
    key_ciph  = FIPS;
    run_key(FIPS, 0, 1, 0, '0, -1);
    @(negedge clk);
    chk("drop_not_queued", key_ready, 1);

    // reset at idx 5, then the all-zero key
    key_valid = 1'b1;
    key_ciph  = FIPS;
    run_key(FIPS, 0, 0, 0, '0, 5);
    key_valid = 1'b1;
    key_ciph  = '0;
    run_key('0, 0, 0, 0, '0, -1);
    chk("zero_idx10", obs[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // back-to-back keys with key_valid held high
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    key_ciph  = ka;
    run_key(ka, 0, 0, 1, kb, -1);
    run_key(kb, 0, 0, 0, '0, -1);

    // random keys under backpressure
    for (int t = 0; t < 4; t++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      key_valid = 1'b1;
      key_ciph  = ka;
      run_key(ka, 1, 0, 0, '0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes128_inv_key_sched.md
AES128_INV_KEY_SCHED -- requirements
Module: aes128_inv_key_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 128, as the key/round-key width; only 128 is supported.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock, with all state on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port key_valid_i, input, 1 bit: cipher key offered.
REQ-005 SHALL have port key_ciph_i, input, WIDTH bits: cipher key, with w0 = [127:96] and w3 = [31:0].
REQ-006 SHALL have port key_ready_o, output, 1 bit: block can accept a key.
REQ-007 SHALL have port rkey_o, output, WIDTH bits: current decryption round key.
REQ-008 SHALL have port rkey_idx_o, output, 4 bits: round index of rkey_o (10 down to 0).
REQ-009 SHALL have port rkey_valid_o, output, 1 bit: rkey_o/rkey_idx_o are valid.
REQ-010 SHALL have port rkey_ready_i, input, 1 bit: consumer accepts the current round key.
REQ-011 SHALL have port rkey_last_o, output, 1 bit: high together with rkey_valid_o when rkey_idx_o = 0.

Function
REQ-012 SHALL implement a state machine with states IDLE, FWD and STREAM; key_ready_o SHALL be high only in IDLE.
REQ-013 SHALL, in IDLE with key_valid_i high, latch key_ciph_i on that edge and go to FWD, with the round counter set to 0.
REQ-014 SHALL, in FWD, perform one forward AES-128 expansion round per cycle (RotWord, SubWord, rcon[r]) for 10 cycles, then go to STREAM with the round-10 key held.
REQ-015 SHALL raise rkey_valid_o 10 cycles after the key-accept edge, presenting the round-10 key with rkey_idx_o = 10.
REQ-016 SHALL, in STREAM, treat a beat as transferred on an edge where rkey_valid_o and rkey_ready_i are both high.
REQ-017 SHALL, on each transferred beat, compute round key r-1 from round key r with w'3 = w3^w2, w'2 = w2^w1, w'1 = w1^w0, w'0 = w0^SubWord(RotWord(w'3))^rcon[r-1]; the new key is valid on the next cycle.
REQ-018 SHALL hold rkey_o and rkey_idx_o stable while rkey_valid_o is high and rkey_ready_i is low.
REQ-019 SHALL, on the transfer of the index-0 beat, drop rkey_valid_o and rkey_last_o and return to IDLE; key_ready_o is high on the next cycle.
REQ-020 SHALL ignore key_valid_i outside IDLE; a new key is not queued.
REQ-021 SHALL support zero-bubble streaming: with rkey_ready_i held high, the 11 keys appear on 11 consecutive cycles.
REQ-022 SHALL use the rcon table 01,02,04,08,10,20,40,80,1b,36 in the top byte, with the remaining 24 bits zero.

Reset
REQ-023 SHALL, with rst_n_i low, immediately force state IDLE, the counter to 0, rkey_o to 0, rkey_idx_o to 0, and rkey_valid_o and rkey_last_o to 0, with key_ready_o driven high.
REQ-024 SHALL abort any FWD or STREAM operation on reset, discarding the partial sequence; after release the block accepts a new key.

Configuration
REQ-025 SHALL, with macro AES_EQ_INV_CIPHER_KEY_EN defined, apply InvMixColumns to rkey_o for indices 9..1 (equivalent-inverse-cipher keys); indices 10 and 0 are unmodified.
REQ-026 SHALL, without AES_EQ_INV_CIPHER_KEY_EN, output raw round keys for all indices, and the InvMixColumns logic SHALL be absent.
REQ-027 SHALL, with the macro defined, keep the same latency and handshake, and the internal chaining SHALL use raw keys only.

Structure
REQ-028 SHALL take the rcon table, the WIDTH/word constants and the state enumeration from the shared package aes_pkg.
REQ-029 SHALL instantiate a combinational sub-module aes_sbox_word (four byte S-boxes, 32-bit in/out), shared between the FWD and STREAM datapaths.
REQ-030 SHALL be synthesizable RTL without latches; all registers reset asynchronously.

Verification
REQ-031 SHALL cover the FIPS-197 key: key 2b7e151628aed2a6abf7158809cf4f3c with rkey_ready_i=1 -> idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, idx1 = a0fafe1788542cb123a339392a6c7605, idx0 = the input key, then last.
REQ-032 SHALL cover backpressure: the same key with rkey_ready_i toggled randomly -> identical 11-key sequence, with outputs stable during stalls.
REQ-033 SHALL cover a busy-key drop: key_valid_i pulsed during FWD with key 000102030405060708090a0b0c0d0e0f -> ignored, and the first key's sequence is unchanged.
REQ-034 SHALL cover mid-stream reset: rst_n_i low at idx 5 -> all outputs 0 and key_ready_o=1; then the all-zero key -> idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-035 SHALL cover the macro-defined build with the FIPS-197 key -> idx10 and idx0 equal raw keys, and idx9 = InvMixColumns(raw round-9 key) checked against a reference model.
REQ-036 SHALL cover back-to-back keys: key_valid_i held high -> the second key is accepted on the cycle after the idx0 transfer, and its round-10 key follows 10 cycles later.
